// File: rtl/share_split_if.sv
// Lane-width type and valid/ready bus bundle for the share_split secret-sharing pipeline.
// The slave modport is the pipeline side; the master modport is the producer/consumer side.
package share_split_pkg;
    typedef struct packed {
        logic is256;
        logic is128;
        logic is64;
    } width_t;
endpackage

interface share_split_if;
    import share_split_pkg::*;

    logic             valid_i;
    logic             ready_o;
    logic [7:0][31:0] x_32_i;
    logic [7:0][31:0] r_32_i;
    width_t           width_i;
    logic             valid_o;
    logic             ready_i;
    logic [7:0][31:0] ps_32_o;
    logic [7:0][31:0] sc_32_o;

    modport slave (
        input  valid_i, x_32_i, r_32_i, width_i, ready_i,
        output ready_o, valid_o, ps_32_o, sc_32_o
    );

    modport master (
        output valid_i, x_32_i, r_32_i, width_i, ready_i,
        input  ready_o, valid_o, ps_32_o, sc_32_o
    );
endinterface

// File: rtl/share_split.sv
// Pipelined lane-configurable subtractor: splits x into shares ps = r and sc = (x - r) per lane.
// Level 0 registers the raw beat, levels 1..8 hold the results of stages 0..7; level 8 drives the outputs.
module share_split
    import share_split_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    share_split_if.slave bus
);
    localparam int NL = 8;        // limbs per word
    localparam int LW = 32;       // bits per limb
    localparam int NV = NL + 1;   // register levels: raw input plus one per stage

    typedef logic [NL-1:0][LW-1:0] word_t;

    typedef struct packed {
        logic          vld;
        width_t        w;
        logic [NL-1:0] b;
        word_t         r;
        word_t         d;
    } level_t;

    level_t level_q [NV];
    level_t level_d [NV];
    logic   adv;

    // Borrow enable for boundary k between limb k and limb k+1; flags are used literally.
    function automatic logic [NL-2:0] boundary_en(input width_t w);
        logic [NL-2:0] en;
        en    = '0;
        en[0] = w.is64;
        en[1] = w.is128;
        en[2] = w.is64;
        en[3] = w.is256;
        en[4] = w.is64;
        en[5] = w.is128;
        en[6] = w.is64;
        return en;
    endfunction

    assign adv         = !level_q[NV-1].vld || bus.ready_i;
    assign bus.ready_o = adv;
    assign bus.valid_o = level_q[NV-1].vld;
    assign bus.ps_32_o = level_q[NV-1].r;
    assign bus.sc_32_o = level_q[NV-1].d;

    always_comb begin
        level_t        nxt;
        logic [NL-2:0] en;
        nxt = '0;
        en  = '0;
        for (int s = 0; s < NV; s++) begin
            level_d[s] = level_q[s];
        end
        if (adv) begin
            level_d[0].vld = bus.valid_i;
            level_d[0].w   = bus.width_i;
            level_d[0].b   = '0;
            level_d[0].r   = bus.r_32_i;
            level_d[0].d   = bus.x_32_i;

            // Stage 0: independent per-limb subtract with local borrow.
            nxt = level_q[0];
            for (int j = 0; j < NL; j++) begin
                nxt.d[j] = level_q[0].d[j] - level_q[0].r[j];
                nxt.b[j] = level_q[0].d[j] < level_q[0].r[j];
            end
            level_d[1] = nxt;

            // Stage i: ripple the borrow from limb i-1 into limb i when the boundary is enabled.
            for (int i = 1; i < NL; i++) begin
                nxt = level_q[i];
                en  = boundary_en(level_q[i].w);
                if (level_q[i].b[i-1] && en[i-1]) begin
                    nxt.d[i] = level_q[i].d[i] - 32'd1;
                    nxt.b[i] = level_q[i].b[i] | (level_q[i].d[i] == '0);
                end
                level_d[i+1] = nxt;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int s = 0; s < NV; s++) begin
                level_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NV; s++) begin
                level_q[s] <= level_d[s];
            end
        end
    end
endmodule

// File: tb/tb_share_split.sv
// Self-checking bench for share_split: directed lane cases, streaming with backpressure, reset mid-stream.
// Expected shares come from a lane-wise big-number model queued at acceptance.
module tb_share_split;
    import share_split_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    share_split_if bus ();

    share_split dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [255:0] x;
        logic [255:0] r;
        logic [255:0] sc;
        width_t       w;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int lane_bits(input width_t w);
        if (w.is256) return 256;
        if (w.is128) return 128;
        if (w.is64)  return 64;
        return 32;
    endfunction

    function automatic logic [255:0] lane_mask(input int lw);
        logic [255:0] one;
        one = 256'd1;
        if (lw == 256) return '1;
        return (one << lw) - 256'd1;
    endfunction

    function automatic logic [255:0] lane_sub(input logic [255:0] a, input logic [255:0] b, input width_t w);
        int           lw;
        logic [255:0] m, res, pa, pb;
        lw  = lane_bits(w);
        m   = lane_mask(lw);
        res = '0;
        for (int k = 0; k < 256 / lw; k++) begin
            pa  = (a >> (k * lw)) & m;
            pb  = (b >> (k * lw)) & m;
            res = res | (((pa - pb) & m) << (k * lw));
        end
        return res;
    endfunction

    function automatic logic [255:0] lane_add(input logic [255:0] a, input logic [255:0] b, input width_t w);
        int           lw;
        logic [255:0] m, res, pa, pb;
        lw  = lane_bits(w);
        m   = lane_mask(lw);
        res = '0;
        for (int k = 0; k < 256 / lw; k++) begin
            pa  = (a >> (k * lw)) & m;
            pb  = (b >> (k * lw)) & m;
            res = res | (((pa + pb) & m) << (k * lw));
        end
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    function automatic width_t rand_width();
        case ($urandom_range(0, 3))
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    task automatic idle();
        bus.valid_i = 1'b0;
        bus.x_32_i  = '0;
        bus.r_32_i  = '0;
        bus.width_i = 3'b000;
        bus.ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.x_32_i  = '1;
        bus.r_32_i  = '1;
        repeat (3) @(negedge clk);
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
        total++; if (bus.ps_32_o !== '0) begin bad++; $display("FAIL reset_ps: got %h want 0", bus.ps_32_o); end
        total++; if (bus.sc_32_o !== '0) begin bad++; $display("FAIL reset_sc: got %h want 0", bus.sc_32_o); end
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", bus.ready_o); end
        $display("test_reset done");
    endtask

    task automatic test_directed();
        logic [255:0] tx [5];
        logic [255:0] tr [5];
        logic [255:0] tsc[5];
        width_t       tw [5];
        exp_t         e;
        int           lat;
        logic         got;
        // 256-bit full borrow chain
        tx[0] = 256'd0; tr[0] = 256'd1; tw[0] = 3'b111; tsc[0] = '1;
        // 32-bit lanes: no cross-limb borrow
        tx[1] = 256'd0; tw[1] = 3'b000; tsc[1] = '1;
        tr[1] = {8{32'h0000_0001}};
        // 64-bit lanes: borrow stops at limb 1
        tx[2] = 256'h1_0000_0000; tr[2] = 256'd1; tw[2] = 3'b001;
        tsc[2] = 256'h0000_0000_FFFF_FFFF;
        // 128-bit lanes: borrow out of limb 3 dropped
        tx[3] = 256'd1 << 128; tr[3] = 256'd1; tw[3] = 3'b011;
        tsc[3] = (256'd1 << 128) | {128'd0, {4{32'hFFFF_FFFF}}};
        // non-thermometer: only boundary 3 enabled
        tx[4] = 256'd0; tr[4] = 256'd1 << 96; tw[4] = 3'b100;
        tsc[4] = {96'd0, 64'hFFFF_FFFF_FFFF_FFFF, 96'd0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.valid_i = 1'b1;
            bus.x_32_i  = tx[c];
            bus.r_32_i  = tr[c];
            bus.width_i = tw[c];
            #1;
            total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL dir%0d_ready: got %b want 1", c, bus.ready_o); end
            e.x = tx[c]; e.r = tr[c]; e.sc = tsc[c]; e.w = tw[c];
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.valid_i = 1'b0;
            lat = 0;
            got = 1'b0;
            while (lat < 20 && !got) begin
                @(posedge clk);
                lat++;
                #1;
                got = bus.valid_o;
            end
            total++; if (lat !== 8) begin bad++; $display("FAIL dir%0d_latency: got %0d want 8", c, lat); end
            e = sb.pop_front();
            total++; if (bus.sc_32_o !== e.sc) begin bad++; $display("FAIL dir%0d_sc: got %h want %h", c, bus.sc_32_o, e.sc); end
            total++; if (bus.ps_32_o !== e.r) begin bad++; $display("FAIL dir%0d_ps: got %h want %h", c, bus.ps_32_o, e.r); end
            $display("dir case %0d width=%b latency=%0d sc=%h", c, tw[c], lat, bus.sc_32_o);
        end
        @(negedge clk);
    endtask

    task automatic test_stream_backpressure();
        int           cyc, sent, got;
        logic         pending, stall_prev;
        logic [255:0] held_ps, held_sc;
        exp_t         cur, e;
        cyc = 0; sent = 0; got = 0;
        pending = 1'b0; stall_prev = 1'b0;
        held_ps = '0; held_sc = '0;
        cur.x = '0; cur.r = '0; cur.sc = '0; cur.w = 3'b000;
        while (got < 20 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.ready_i = !(cyc >= 12 && cyc < 17);
            if (!pending && sent < 20 && $urandom_range(0, 3) != 0) begin
                cur.x  = rand256();
                cur.r  = rand256();
                cur.w  = rand_width();
                cur.sc = lane_sub(cur.x, cur.r, cur.w);
                bus.x_32_i  = cur.x;
                bus.r_32_i  = cur.r;
                bus.width_i = cur.w;
                pending = 1'b1;
            end
            bus.valid_i = pending;
            #1;
            if (stall_prev) begin
                total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", bus.valid_o); end
                total++; if (bus.ps_32_o !== held_ps) begin bad++; $display("FAIL stall_ps: got %h want %h", bus.ps_32_o, held_ps); end
                total++; if (bus.sc_32_o !== held_sc) begin bad++; $display("FAIL stall_sc: got %h want %h", bus.sc_32_o, held_sc); end
                total++; if (bus.ready_o !== bus.ready_i) begin bad++; $display("FAIL stall_ready: got %b want %b", bus.ready_o, bus.ready_i); end
            end
            if (bus.valid_o && bus.ready_i) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL stream_extra: got unexpected beat sc=%h want none", bus.sc_32_o);
                end else begin
                    e = sb.pop_front();
                    if (bus.sc_32_o !== e.sc) begin bad++; $display("FAIL stream_sc beat%0d: got %h want %h", got, bus.sc_32_o, e.sc); end
                    total++; if (bus.ps_32_o !== e.r) begin bad++; $display("FAIL stream_ps beat%0d: got %h want %h", got, bus.ps_32_o, e.r); end
                    total++;
                    if (lane_add(bus.ps_32_o, bus.sc_32_o, e.w) !== e.x) begin
                        bad++; $display("FAIL stream_recombine beat%0d: got %h want %h", got, lane_add(bus.ps_32_o, bus.sc_32_o, e.w), e.x);
                    end
                    $display("stream beat %0d width=%b cycle=%0d sc=%h", got, e.w, cyc, bus.sc_32_o);
                end
                got++;
            end
            stall_prev = bus.valid_o && !bus.ready_i;
            held_ps    = bus.ps_32_o;
            held_sc    = bus.sc_32_o;
            if (pending && bus.ready_o) begin
                sb.push_back(cur);
                pending = 1'b0;
                sent++;
            end
        end
        idle();
        total++; if (got !== 20) begin bad++; $display("FAIL stream_count: got %0d want 20", got); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL stream_leftover: got %0d want 0", sb.size()); end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        int   n, lat;
        logic got;
        @(negedge clk);
        bus.ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.valid_i = 1'b1;
            bus.x_32_i  = rand256();
            bus.r_32_i  = rand256();
            bus.width_i = rand_width();
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        n = 0;
        while (n < 20 && !bus.valid_o) begin
            @(negedge clk);
            n++;
        end
        total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid: got %b want 1", bus.valid_o); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.valid_o); end
        total++; if (bus.ps_32_o !== '0) begin bad++; $display("FAIL midrst_ps: got %h want 0", bus.ps_32_o); end
        total++; if (bus.sc_32_o !== '0) begin bad++; $display("FAIL midrst_sc: got %h want 0", bus.sc_32_o); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", bus.ready_o); end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        e.x = rand256(); e.r = rand256(); e.w = 3'b011;
        e.sc = lane_sub(e.x, e.r, e.w);
        bus.valid_i = 1'b1;
        bus.x_32_i  = e.x;
        bus.r_32_i  = e.r;
        bus.width_i = e.w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 20 && !got) begin
            @(posedge clk);
            lat++;
            #1;
            got = bus.valid_o;
        end
        total++; if (lat !== 8) begin bad++; $display("FAIL post_rst_latency: got %0d want 8", lat); end
        e = sb.pop_front();
        total++; if (bus.sc_32_o !== e.sc) begin bad++; $display("FAIL post_rst_sc: got %h want %h", bus.sc_32_o, e.sc); end
        total++; if (bus.ps_32_o !== e.r) begin bad++; $display("FAIL post_rst_ps: got %h want %h", bus.ps_32_o, e.r); end
        $display("post-reset beat latency=%0d sc=%h", lat, bus.sc_32_o);
        @(negedge clk);
    endtask

    initial begin
        idle();
        test_reset();
        test_directed();
        test_stream_backpressure();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/share_split.md
# share_split

Pipelined lane-configurable subtractor that splits a secret value into two additive shares: `ps = r` (random mask) and `sc = (x − r) mod 2^w` per lane.
It is the inverse of `adder_tree`, which recombines `ps + sc` with the same lane-width carry topology.
It sits between the PRNG mask source and the share output path, adds a valid/ready handshake, and carries the lane width with each beat.

## Interface
- No parameters. Geometry is fixed: 8 limbs × 32 bits, 256-bit word, 8 pipeline stages.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: input beat valid.
- `ready_o` out 1: block can accept the input beat this cycle.
- `x_32_i` in [7:0][31:0]: value to split, limb 0 is least significant.
- `r_32_i` in [7:0][31:0]: random mask, same limb order.
- `width_i` in `width_t`: lane width, thermometer coded.
  - 32-bit: no flag set.
  - 64-bit: `is64`.
  - 128-bit: `is64`, `is128`.
  - 256-bit: `is64`, `is128`, `is256`.
- `valid_o` out 1: output beat valid.
- `ready_i` in 1: downstream accepts the output beat.
- `ps_32_o` out [7:0][31:0]: mask share, equal to `r` of the same beat.
- `sc_32_o` out [7:0][31:0]: difference share `x − r`, lane-wise.

## Operation
- A beat is accepted when `valid_i && ready_o` at a rising edge.
- `width_i` is sampled with the beat and travels down the pipeline. A width change on later beats never affects beats already in flight.
- Boundary k (k = 0..6) lies between limb k and limb k+1. Its borrow enable `en[k]`:
  - k ∈ {0, 2, 4, 6}: `is64`.
  - k ∈ {1, 5}: `is128`.
  - k = 3: `is256`.
  - Any non-thermometer flag combination is applied literally, bit by bit.
- Stage 0, every limb j: `d[j] = x[j] − r[j]` (32-bit wrap), `b[j] = (x[j] < r[j])`.
- Stage i (i = 1..7) updates only limb i:
  - If `b[i-1] && en[i-1]`: `d[i] ← d[i] − 1` and `b[i] ← b[i] | (d[i] == 0 before the decrement)`.
  - Otherwise limb i is unchanged.
  - All other limbs, their borrows, `r`, and the width pass through unchanged.
- The borrow out of limb 7, and any borrow across a disabled boundary, is discarded. This gives modulo 2^w per lane.
- `ps_32_o` is the `r` of the same beat, delayed in lockstep with the data.
- Invariant: feeding `ps` and `sc` into `adder_tree` with the same width returns `x`.
- Each stage holds a valid bit, limbs, borrows, mask and width.
- Global advance: `adv = !valid_o || ready_i`, and `ready_o = adv`.
  - When `adv` is 0, every stage holds, including bubbles. Bubbles are not compacted.
- Reset (asynchronous, any time, including mid-stream):
  - All valid bits, data, borrows and widths clear to 0 immediately.
  - `valid_o` = 0, `ps_32_o` = 0, `sc_32_o` = 0.
  - `ready_o` = 1 while reset is asserted and after release.
  - In-flight beats are lost. The first beat after release is processed normally.

## Timing
- Latency: a beat accepted at edge N appears with `valid_o` = 1 after edge N+8, provided no stall occurs.
- Throughput: one beat per cycle with `ready_i` held at 1.
- Each stall cycle (`valid_o && !ready_i`) adds one cycle to every in-flight beat.
- While stalled, `valid_o`, `ps_32_o` and `sc_32_o` hold stable and `ready_o` = 0.
- `ready_o` depends combinationally on `ready_i` and registered `valid_o` only. There is no path from `valid_i`.
- The output beat transfers on an edge where `valid_o && ready_i`.
- The next stage's contents appear in the same edge, so back-to-back output is possible.
- If `valid_i` = 0 while `adv` = 1, a bubble (valid 0) enters stage 0.
- Critical path per stage: one 32-bit subtract, or one 32-bit decrement plus a zero detect.

## Test plan
- 256-bit mode, x = 0, r = 1 → after 8 cycles:
  - `sc` limbs = all `FFFFFFFF`.
  - `ps` limb 0 = 1, other limbs 0.
- 32-bit mode, x = 0, r limb i = 1 for all i → every `sc` limb = `FFFFFFFF`, no cross-limb borrow.
- 64-bit mode, x = {limb1 = 1, limb0 = 0}, r = {limb0 = 1}:
  - `sc` limb 0 = `FFFFFFFF`, limb 1 = 0.
  - Limb 2 is unaffected by the borrow out of limb 1.
- 128-bit mode, x limb 4 = 1 and all other limbs 0, r limb 0 = 1:
  - `sc` limbs 0..3 = `FFFFFFFF`, limb 4 = 1.
  - Lanes are independent: the borrow out of limb 3 is dropped.
- Streaming and backpressure: 20 random beats with mixed widths, `ready_i` low for 5 cycles mid-stream:
  - Outputs arrive in order, stay stable while stalled, and no beat is lost or duplicated.
  - `adder_tree(ps, sc)` equals the original x for every beat.
- Reset mid-stream: assert `rst_n_i` low with 4 beats in flight → `valid_o` drops immediately and outputs are 0. After release, a new beat emerges 8 cycles after it is accepted, with the correct value.
